rf_dump_reader: RTL and testbench

RF_DUMP_READER -- requirements
Module: rf_dump_reader

---
 rtl/riscv_pkg.sv | 16 +
 rtl/rf_dump_reader_if.sv | 29 ++
 rtl/rf_dump_reader.sv | 107 ++++++++++
 tb/tb_rf_dump_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants plus the state type of the register-file dump reader.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] X0       = 5'd0;
  localparam logic [4:0] LAST_REG = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage : riscv_pkg

// File: rtl/rf_dump_reader_if.sv
// Control, register-file read port and word stream of the dump reader.
// master = the reader, slave = the register file / consumer side.
interface rf_dump_reader_if #(
  parameter int XLEN = riscv_pkg::XLEN
) ();

  logic            start;
  logic            abort;
  logic [4:0]      rf_addr;
  logic [XLEN-1:0] rf_data;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_idx;
  logic [XLEN-1:0] out_data;
  logic            out_last;
  logic            busy;
  logic            done;

  modport master (
    input  start, abort, rf_data, out_ready,
    output rf_addr, out_valid, out_idx, out_data, out_last, busy, done
  );

  modport slave (
    output start, abort, rf_data, out_ready,
    input  rf_addr, out_valid, out_idx, out_data, out_last, busy, done
  );

endinterface : rf_dump_reader_if

// File: rtl/rf_dump_reader.sv
// Streams the architectural register file out one word at a time through a
// valid/ready port, reading each register on a dedicated combinational read port.
module rf_dump_reader
  import riscv_pkg::*;
#(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter bit SKIP_X0 = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  rf_dump_reader_if.master   dump
);

  dump_state_t     state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [4:0]      out_idx_q, out_idx_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  logic [4:0]      rf_addr;
  logic            out_valid;
  logic            busy;
  logic            done;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    rf_addr    = X0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // A start coinciding with abort is treated as cancelled before it began.
        if (dump.start && !dump.abort) begin
          state_d = READ;
          idx_d   = SKIP_X0 ? 5'd1 : X0;
        end
      end

      READ: begin
        rf_addr = idx_q;
        if (dump.abort) begin
          state_d = IDLE;
        end else begin
          out_data_d = dump.rf_data;
          out_idx_d  = idx_q;
          out_last_d = (idx_q == LAST_REG);
          state_d    = SEND;
        end
      end

      SEND: begin
        out_valid = 1'b1;
        if (dump.abort) begin
          state_d = IDLE;
        end else if (dump.out_ready) begin
          // x31 is terminal, so the increment below never wraps.
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = READ;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= X0;
      out_idx_q  <= X0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign dump.rf_addr   = rf_addr;
  assign dump.out_valid = out_valid;
  assign dump.out_idx   = out_idx_q;
  assign dump.out_data  = out_data_q;
  assign dump.out_last  = out_last_q;
  assign dump.busy      = busy;
  assign dump.done      = done;

endmodule : rf_dump_reader

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: one instance per SKIP_X0 setting sharing a modelled
// register file; a word-level monitor checks every accepted word against the model.
module tb_rf_dump_reader;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_dump_reader_if #(.XLEN(XLEN)) bus0 ();
  rf_dump_reader_if #(.XLEN(XLEN)) bus1 ();

  rf_dump_reader #(.XLEN(XLEN), .SKIP_X0(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .dump  (bus0.master)
  );

  rf_dump_reader #(.XLEN(XLEN), .SKIP_X0(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .dump  (bus1.master)
  );

  // Register file with one write port whose data is bypassed to the read ports.
  logic [XLEN-1:0] regs [32];
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  assign bus0.rf_data = (wr_en && wr_addr == bus0.rf_addr) ? wr_data : regs[bus0.rf_addr];
  assign bus1.rf_data = (wr_en && wr_addr == bus1.rf_addr) ? wr_data : regs[bus1.rf_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: the word for register i must carry exp_val[i]; indices run upward.
  logic [XLEN-1:0] exp_val [32];
  int              exp_next [2];
  int              words [2];
  int              dones [2];
  logic            prev_stall [2];
  logic [4:0]      prev_idx [2];
  logic [XLEN-1:0] prev_data [2];
  logic            prev_last [2];

  task automatic mon(input int d, input logic v, input logic r, input logic [4:0] idx,
                     input logic [XLEN-1:0] data, input logic last, input logic dn);
    if (reset) begin
      prev_stall[d] = 1'b0;
      return;
    end
    if (v && prev_stall[d]) begin
      check("hold_idx", 64'(idx), 64'(prev_idx[d]));
      check("hold_data", 64'(data), 64'(prev_data[d]));
      check("hold_last", 64'(last), 64'(prev_last[d]));
    end
    if (v && r) begin
      check("word_idx", 64'(idx), 64'(exp_next[d]));
      check("word_data", 64'(data), 64'(exp_val[idx]));
      check("word_last", 64'(last), 64'(exp_next[d] == 31));
      exp_next[d]++;
      words[d]++;
    end
    if (dn) dones[d]++;
    prev_stall[d] = v && !r;
    prev_idx[d]   = idx;
    prev_data[d]  = data;
    prev_last[d]  = last;
  endtask

  always @(negedge clk) begin
    mon(0, bus0.out_valid, bus0.out_ready, bus0.out_idx, bus0.out_data, bus0.out_last, bus0.done);
    mon(1, bus1.out_valid, bus1.out_ready, bus1.out_idx, bus1.out_data, bus1.out_last, bus1.done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  task automatic preload_fixed();
    for (int i = 0; i < 32; i++) begin
      regs[i]    = XLEN'(32'h1000_0000 + i);
      exp_val[i] = XLEN'(32'h1000_0000 + i);
    end
  endtask

  task automatic start_dump(input int d);
    exp_next[d] = d;
    words[d]    = 0;
    dones[d]    = 0;
    if (d == 0) bus0.start = 1'b1;
    else        bus1.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int max_cyc, output int lat);
    lat = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      tick();
      if ((d == 0) ? bus0.done : bus1.done) begin
        lat = k;
        return;
      end
    end
    check("done_timeout", 64'(0), 64'(1));
  endtask

  // Sampled right after the edge that follows reset; every output is at its reset value.
  task automatic check_reset_outputs(input int d);
    if (d == 0) begin
      check("rst_valid0", 64'(bus0.out_valid), 64'(0));
      check("rst_idx0", 64'(bus0.out_idx), 64'(0));
      check("rst_data0", 64'(bus0.out_data), 64'(0));
      check("rst_last0", 64'(bus0.out_last), 64'(0));
      check("rst_busy0", 64'(bus0.busy), 64'(0));
      check("rst_done0", 64'(bus0.done), 64'(0));
      check("rst_addr0", 64'(bus0.rf_addr), 64'(0));
    end else begin
      check("rst_valid1", 64'(bus1.out_valid), 64'(0));
      check("rst_idx1", 64'(bus1.out_idx), 64'(0));
      check("rst_data1", 64'(bus1.out_data), 64'(0));
      check("rst_last1", 64'(bus1.out_last), 64'(0));
      check("rst_busy1", 64'(bus1.busy), 64'(0));
      check("rst_done1", 64'(bus1.done), 64'(0));
      check("rst_addr1", 64'(bus1.rf_addr), 64'(0));
    end
  endtask

  task automatic finish_dump(input int d, input string name);
    int lat;
    wait_done(d, 400, lat);
    tick();
    check({name, "_words"}, 64'(words[d]), 64'(32 - d));
    check({name, "_dones"}, 64'(dones[d]), 64'(1));
    $display("dump %s dut%0d: %0d words, %0d done pulses", name, d, words[d], dones[d]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = 5'd0;
    wr_data    = '0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    set_ready(1'b0);
    for (int d = 0; d < 2; d++) begin
      exp_next[d] = d; words[d] = 0; dones[d] = 0; prev_stall[d] = 1'b0;
    end
    preload_fixed();
    repeat (3) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset = 1'b0;
    tick();

    // Full dump with consumer always ready: latency, throughput, last flag.
    set_ready(1'b1);
    start_dump(0);
    check("read_valid_low", 64'(bus0.out_valid), 64'(0));
    check("read_busy", 64'(bus0.busy), 64'(1));
    tick();
    check("first_valid", 64'(bus0.out_valid), 64'(1));
    check("send_rf_addr", 64'(bus0.rf_addr), 64'(0));
    wait_done(0, 200, lat);
    check("done_lat_full", 64'(lat + 1), 64'(64));
    tick();
    check("idle_busy", 64'(bus0.busy), 64'(0));
    check("full_words", 64'(words[0]), 64'(32));
    check("full_dones", 64'(dones[0]), 64'(1));
    $display("dump full dut0: %0d words, %0d done pulses", words[0], dones[0]);

    // SKIP_X0 instance starts at x1.
    start_dump(1);
    check("skip_rf_addr", 64'(bus1.rf_addr), 64'(1));
    tick();
    check("skip_first_idx", 64'(bus1.out_idx), 64'(1));
    check("skip_first_data", 64'(bus1.out_data), 64'(32'h1000_0001));
    wait_done(1, 200, lat);
    check("done_lat_skip", 64'(lat + 1), 64'(62));
    tick();
    check("skip_words", 64'(words[1]), 64'(31));
    check("skip_dones", 64'(dones[1]), 64'(1));
    $display("dump skip dut1: %0d words, %0d done pulses", words[1], dones[1]);

    // Back-pressure on word 3.
    start_dump(0);
    repeat (6) tick();
    set_ready(1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus0.out_valid), 64'(1));
      check("stall_idx", 64'(bus0.out_idx), 64'(3));
      check("stall_data", 64'(bus0.out_data), 64'(32'h1000_0003));
      if (i < 4) tick();
    end
    set_ready(1'b1);
    tick();
    check("stall_read4_valid", 64'(bus0.out_valid), 64'(0));
    tick();
    check("stall_next_valid", 64'(bus0.out_valid), 64'(1));
    check("stall_next_idx", 64'(bus0.out_idx), 64'(4));
    finish_dump(0, "stall");

    // Write to x7 in the very cycle it is read: bypassed data is captured.
    start_dump(0);
    repeat (14) tick();
    wr_en      = 1'b1;
    wr_addr    = 5'd7;
    wr_data    = XLEN'(32'hDEAD_BEEF);
    exp_val[7] = XLEN'(32'hDEAD_BEEF);
    tick();
    regs[7] = XLEN'(32'hDEAD_BEEF);
    wr_en   = 1'b0;
    check("bypass_idx", 64'(bus0.out_idx), 64'(7));
    check("bypass_data", 64'(bus0.out_data), 64'(32'hDEAD_BEEF));
    finish_dump(0, "bypass");
    preload_fixed();

    // Abort during SEND of word 10, then a clean restart.
    start_dump(0);
    repeat (21) tick();
    check("pre_abort_idx", 64'(bus0.out_idx), 64'(10));
    bus0.abort = 1'b1;
    set_ready(1'b0);
    tick();
    bus0.abort = 1'b0;
    set_ready(1'b1);
    check("abort_valid", 64'(bus0.out_valid), 64'(0));
    check("abort_busy", 64'(bus0.busy), 64'(0));
    check("abort_done", 64'(bus0.done), 64'(0));
    repeat (5) tick();
    check("abort_no_done", 64'(dones[0]), 64'(0));
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    check("start_with_abort", 64'(bus0.busy), 64'(0));
    start_dump(0);
    tick();
    check("restart_idx", 64'(bus0.out_idx), 64'(0));
    finish_dump(0, "restart");

    // start while busy is ignored; reset in SEND of word 20 overrides a start.
    start_dump(0);
    repeat (5) tick();
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (35) tick();
    check("pre_reset_idx", 64'(bus0.out_idx), 64'(20));
    check("pre_reset_valid", 64'(bus0.out_valid), 64'(1));
    reset      = 1'b1;
    bus0.start = 1'b1;
    tick();
    reset      = 1'b0;
    bus0.start = 1'b0;
    check_reset_outputs(0);
    tick();
    check("post_reset_busy", 64'(bus0.busy), 64'(0));
    check("reset_no_done", 64'(dones[0]), 64'(0));

    // Randomized contents and back-pressure on either instance.
    for (int it = 0; it < 6; it++) begin
      int d;
      d = int'($urandom_range(1, 0));
      for (int i = 0; i < 32; i++) begin
        regs[i]    = XLEN'($urandom);
        exp_val[i] = regs[i];
      end
      set_ready($urandom_range(3, 0) != 0);
      start_dump(d);
      lat = -1;
      for (int k = 0; k < 600 && lat < 0; k++) begin
        set_ready($urandom_range(3, 0) != 0);
        tick();
        if ((d == 0) ? bus0.done : bus1.done) lat = k;
      end
      if (lat < 0) check("rand_timeout", 64'(0), 64'(1));
      tick();
      check("rand_words", 64'(words[d]), 64'(32 - d));
      check("rand_dones", 64'(dones[d]), 64'(1));
      $display("dump random dut%0d: %0d words, %0d done pulses", d, words[d], dones[d]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rf_dump_reader
